// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA timing generator and frame-buffer scanout for the data
// memory's VGA read port. Shows an IMG_W x IMG_H grayscale image in the
// top-left corner of the screen; everything else is black.
// Optional feature macro: VGA_TEST_PATTERN_EN adds input pattern_sel, which
// replaces memory data with eight vertical colour bars across the visible area.
// Memory data is sampled on the tick after the address is issued, so MEM_LAT
// must be shorter than the number of clk cycles between pix_tick pulses.
module vga_frame_reader #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          IMG_W     = 256,
  parameter int          IMG_H     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_tick,
  output logic [31:0] vga_addr,
  input  logic [7:0]  out_data_vga,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [31:0] H_LAST  = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST  = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT   = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT   = 32'(V_ACTIVE);
  localparam logic [31:0] HS_LO   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_HI   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_LO   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_HI   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] IMG_W32 = 32'(IMG_W);
  localparam logic [31:0] IMG_H32 = 32'(IMG_H);

  if (MEM_LAT < 0) begin : g_mem_lat_check
    $error("vga_frame_reader: MEM_LAT must not be negative");
  end

  // Scan position and the running start-of-row offset into the frame buffer
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [31:0]   row_base;
  logic          first_tick;

  // Position decode, widened to 32 bits so every compare has matching widths
  logic [31:0] h32;
  logic [31:0] v32;
  logic        h_last;
  logic        v_last;
  logic        visible;
  logic        in_img;
  logic        hsync_raw;
  logic        vsync_raw;

  // Stage-1 delayed flags, aligned with the address presented to memory
  logic s1_vis;
  logic s1_img;
  logic s1_hs;
  logic s1_vs;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_idx;
  logic [2:0] s1_bar;
  logic       s1_pat;

  // Colour bar index for the current column
  always_comb begin
    bar_idx = 3'(h32 / 32'(BAR_W));
  end
`endif

  assign vga_sync_n = 1'b0;

  // Decode the current counter position into timing and region flags
  always_comb begin
    h32       = 32'(hcnt);
    v32       = 32'(vcnt);
    h_last    = (h32 == H_LAST);
    v_last    = (v32 == V_LAST);
    visible   = (h32 < H_ACT) && (v32 < V_ACT);
    in_img    = (h32 < IMG_W32) && (v32 < IMG_H32);
    hsync_raw = !((h32 >= HS_LO) && (h32 < HS_HI));
    vsync_raw = !((v32 >= VS_LO) && (v32 < VS_HI));
  end

  // Advance the raster counters and the row offset once per pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      row_base <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        hcnt <= '0;
        if (v_last) begin
          vcnt     <= '0;
          row_base <= '0;
        end else begin
          vcnt <= vcnt + 1'b1;
          if (v32 < IMG_H32) begin
            row_base <= row_base + IMG_W32;
          end
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // One-clk frame marker on the first tick after reset and on every frame wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      first_tick  <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        frame_start <= first_tick | (h_last & v_last);
        first_tick  <= 1'b0;
      end
    end
  end

  // Stage 1: issue the read address and delay the region and sync flags
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_addr <= BASE_ADDR;
      s1_vis   <= 1'b0;
      s1_img   <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      s1_bar   <= '0;
      s1_pat   <= 1'b0;
`endif
    end else if (pix_tick) begin
      if (in_img) begin
        vga_addr <= BASE_ADDR + row_base + h32;
      end
      s1_vis <= visible;
      s1_img <= in_img;
      s1_hs  <= hsync_raw;
      s1_vs  <= vsync_raw;
`ifdef VGA_TEST_PATTERN_EN
      s1_bar <= bar_idx;
      s1_pat <= pattern_sel;
`endif
    end
  end

  // Stage 2: sample the returned pixel and drive the DAC-facing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (pix_tick) begin
      vga_hsync   <= s1_hs;
      vga_vsync   <= s1_vs;
      vga_blank_n <= s1_vis;
`ifdef VGA_TEST_PATTERN_EN
      if (s1_vis && s1_pat) begin
        vga_r <= s1_bar[1] ? 8'h00 : 8'hFF;
        vga_g <= s1_bar[2] ? 8'h00 : 8'hFF;
        vga_b <= s1_bar[0] ? 8'h00 : 8'hFF;
      end else
`endif
      if (s1_vis && s1_img) begin
        vga_r <= out_data_vga;
        vga_g <= out_data_vga;
        vga_b <= out_data_vga;
      end else begin
        vga_r <= 8'h00;
        vga_g <= 8'h00;
        vga_b <= 8'h00;
      end
    end
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display-side consumer of the data memory's VGA read port.
- Generates 640x480@60 VGA timing from a pixel-rate clock enable.
- Drives the read address into data memory and turns the returned 8-bit pixel into grayscale RGB plus sync and blank signals for the DAC.
- Shows an IMG_W x IMG_H frame buffer in the top-left corner; everything else is black.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync pulse width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- IMG_W, 256, frame-buffer width in pixels
- IMG_H, 256, frame-buffer height in pixels
- BASE_ADDR, 0, byte address of pixel (0,0) in data memory
- MEM_LAT, 1, clk cycles from vga_addr to valid out_data_vga

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_tick  in  1  pixel-rate clock enable (e.g. every 2nd clk for 25 MHz from 50 MHz)
- vga_addr  out  32  read address to data memory VGA port
- out_data_vga  in  8  pixel byte returned by data memory
- vga_hsync  out  1  horizontal sync, active-low
- vga_vsync  out  1  vertical sync, active-low
- vga_blank_n  out  1  high during visible area
- vga_sync_n  out  1  tied 0 (no sync-on-green)
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- frame_start  out  1  one-clk pulse when hcnt=0, vcnt=0 is entered

Behaviour:
- Reset values on the cycle after rst: hcnt=0, vcnt=0, vga_addr=BASE_ADDR, hsync=1, vsync=1, blank_n=0, r/g/b=0, frame_start=0, pipeline cleared.
- rst wins over pix_tick in the same cycle. Reset mid-frame restarts at (0,0) with no partial-line output.
- State advances only on clk edges with pix_tick=1. Outputs hold between ticks.
- hcnt counts 0..H_TOTAL-1 (800) and wraps to 0. vcnt increments on hcnt wrap, counts 0..V_TOTAL-1 (525), then wraps to 0.
- Visible: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- hsync_raw is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- vsync_raw is low for vcnt in [490, 492).
- In-image: hcnt<IMG_W and vcnt<IMG_H.
- Address generation (no multiplier): vga_addr = BASE_ADDR + row_base + hcnt, registered.
  - row_base increments by IMG_W when the hcnt wrap ends a line with vcnt<IMG_H.
  - row_base returns to 0 on the vcnt wrap.
  - Outside the image region vga_addr holds its last value. Reads there are don't-care and their data is discarded.
- Pipeline: visible, in-image, hsync_raw and vsync_raw pass through a 2-stage tick-enabled delay.
  - Stage 1: address registered.
  - Stage 2: out_data_vga sampled on pix_tick.
  - Requirement: MEM_LAT < clk cycles per tick. Violation is unsupported.
  - Net latency: outputs reflect counter position N two ticks after the counters hold N.
- Pixel mapping: when visible and in-image, r=g=b=out_data_vga; otherwise r=g=b=0.
- blank_n equals the delayed visible flag. When blank_n=0, r/g/b=0 always.
- frame_start is not delayed. It pulses for exactly one clk when the counters wrap to (0,0), and also on the first tick after reset.
- Image larger than the screen is clipped. No wrap is shown past IMG_W within a line.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: adds input port pattern_sel (1 bit). When pattern_sel=1, memory data is ignored and the visible area shows 8 vertical colour bars, each H_ACTIVE/8 = 80 px wide, with colour index = hcnt[9:0]/80.
  - Bar 0 is white (FF,FF,FF). Then yellow, cyan, green, magenta, red, blue, and bar 7 is black.
  - Bars use the same 2-tick latency. vga_addr keeps sequencing normally.
- Undefined: port absent; behaviour is memory grayscale only.

Test Plan:
- Reset mid-line at hcnt=300, then release → next tick counters (1,0); hsync=1, vsync=1, blank_n=0 until the pipeline fills; frame_start pulses once.
- Free-run one frame with pix_tick every 2nd clk → hsync low for exactly 96 ticks starting 2 ticks after hcnt=656; vsync low for 2 lines; 525 lines × 800 ticks between frame_start pulses.
- Memory model returning addr[7:0] with MEM_LAT=1, BASE_ADDR=0x100 → vga_addr=0x100 at (0,0); pixel (5,2) shows r=g=b=0x05 with vga_addr=0x305 issued 2 ticks earlier.
- Image boundary → pixels (255,10) carry data; pixels (256,10) and (10,256) show r=g=b=0 with blank_n=1.
- Blanking: force out_data_vga=0xFF throughout → r/g/b=0 whenever hcnt≥640 or vcnt≥480 (delayed), and 0xFF only inside the 256x256 region.
- With VGA_TEST_PATTERN_EN and pattern_sel=1 → pixel (0,0)=FF,FF,FF; pixel (100,0)=FF,FF,00; pixel (639,479)=00,00,00.
